// File: rtl/rgb666_pkt_arbiter.sv
// rgb666_pkt_arbiter
// Two-input Avalon-ST packet arbiter in front of the RGB666-to-RGBA8888
// widening converter. It grants whole packets (sop..eop) with round-robin
// fairness between the two sources. A beat watchdog cuts off runaway
// packets. The block also keeps per-channel completed-packet counters and
// a sticky error flag.
module rgb666_pkt_arbiter #(
    parameter int DATA_W    = 96,
    parameter int EMPTY_W   = 4,
    parameter int MAX_BEATS = 2048,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cfg_enable,

    input  logic               sink0_valid,
    input  logic               sink0_sop,
    input  logic               sink0_eop,
    input  logic [EMPTY_W-1:0] sink0_empty,
    input  logic [DATA_W-1:0]  sink0_data,
    output logic               sink0_ready,

    input  logic               sink1_valid,
    input  logic               sink1_sop,
    input  logic               sink1_eop,
    input  logic [EMPTY_W-1:0] sink1_empty,
    input  logic [DATA_W-1:0]  sink1_data,
    output logic               sink1_ready,

    input  logic               source_ready,
    output logic               source_valid,
    output logic               source_sop,
    output logic               source_eop,
    output logic [EMPTY_W-1:0] source_empty,
    output logic [DATA_W-1:0]  source_data,

    output logic [1:0]         stat_grant,
    output logic [CNT_W-1:0]   stat_pkt_cnt0,
    output logic [CNT_W-1:0]   stat_pkt_cnt1,
    output logic               stat_err
);

    // Arbiter states. FLUSHn swallows the tail of a packet that the
    // watchdog has already terminated.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT0 = 3'd1;
    localparam logic [2:0] ST_GRANT1 = 3'd2;
    localparam logic [2:0] ST_FLUSH0 = 3'd3;
    localparam logic [2:0] ST_FLUSH1 = 3'd4;

    // The beat counter only has to reach MAX_BEATS-1. The beat that would
    // make it MAX_BEATS always leaves the GRANT state.
    localparam int                BCNT_W    = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(MAX_BEATS - 1);

    logic [2:0]        state_q,      state_d;
    logic              last_owner_q, last_owner_d;
    logic [BCNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt0_q,   pkt_cnt0_d;
    logic [CNT_W-1:0]  pkt_cnt1_q,   pkt_cnt1_d;
    logic              err_q,        err_d;

    // Combinational handshake before the reset gating
    logic              sink0_ready_c;
    logic              sink1_ready_c;
    logic              src_valid_c;
    logic              src_sop_c;
    logic              src_eop_c;

    // Channel selected by the current state and its framing signals
    logic              cur_ch;
    logic              cur_valid;
    logic              cur_sop;
    logic              cur_eop;
    logic              first_beat;
    logic              wd_last;

    // Arbitration requests and stray (sop-less) beats seen while idle
    logic              req0;
    logic              req1;
    logic              stray0;
    logic              stray1;

    assign cur_ch     = (state_q == ST_GRANT1) || (state_q == ST_FLUSH1);
    assign cur_valid  = cur_ch ? sink1_valid : sink0_valid;
    assign cur_sop    = cur_ch ? sink1_sop   : sink0_sop;
    assign cur_eop    = cur_ch ? sink1_eop   : sink0_eop;
    assign first_beat = (beat_cnt_q == '0);
    assign wd_last    = (beat_cnt_q == BEAT_LAST);

    assign req0   = sink0_valid &  sink0_sop & cfg_enable[0];
    assign req1   = sink1_valid &  sink1_sop & cfg_enable[1];
    assign stray0 = sink0_valid & ~sink0_sop & cfg_enable[0];
    assign stray1 = sink1_valid & ~sink1_sop & cfg_enable[1];

    // Arbitration, packet tracking, watchdog and statistics updates
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        beat_cnt_d    = beat_cnt_q;
        pkt_cnt0_d    = pkt_cnt0_q;
        pkt_cnt1_d    = pkt_cnt1_q;
        err_d         = err_q;
        sink0_ready_c = 1'b0;
        sink1_ready_c = 1'b0;
        src_valid_c   = 1'b0;
        src_sop_c     = 1'b0;
        src_eop_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stray beats are accepted and dropped here. Packet starts
                // are held until the grant takes effect.
                sink0_ready_c = stray0;
                sink1_ready_c = stray1;
                if (stray0 || stray1) begin
                    err_d = 1'b1;
                end
                beat_cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_owner_q ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    state_d = ST_GRANT0;
                end else if (req1) begin
                    state_d = ST_GRANT1;
                end
            end

            ST_GRANT0, ST_GRANT1: begin
                if (cur_ch) begin
                    sink1_ready_c = source_ready;
                end else begin
                    sink0_ready_c = source_ready;
                end
                src_valid_c = cur_valid;
                src_sop_c   = cur_sop & first_beat;
                src_eop_c   = cur_eop | wd_last;

                if (cur_valid && source_ready) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    // An sop inside a packet is passed on as an ordinary beat.
                    if (cur_sop && !first_beat) begin
                        err_d = 1'b1;
                    end
                    if (cur_eop || wd_last) begin
                        if (cur_ch) begin
                            pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                        end else begin
                            pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                        end
                        if (cur_eop) begin
                            last_owner_d = cur_ch;
                            state_d      = ST_IDLE;
                        end else begin
                            // Watchdog cut-off. The converter has already
                            // seen a forced eop, so the rest is discarded.
                            err_d   = 1'b1;
                            state_d = cur_ch ? ST_FLUSH1 : ST_FLUSH0;
                        end
                    end
                end
            end

            ST_FLUSH0, ST_FLUSH1: begin
                if (cur_ch) begin
                    sink1_ready_c = 1'b1;
                end else begin
                    sink0_ready_c = 1'b1;
                end
                if (cur_valid && cur_eop) begin
                    last_owner_d = cur_ch;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and statistics registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
            err_q        <= err_d;
        end
    end

    // The data path is a plain mux. Payload is don't-care while source_valid is low.
    assign source_data  = cur_ch ? sink1_data  : sink0_data;
    assign source_empty = cur_ch ? sink1_empty : sink0_empty;

    // While reset is high the handshake is held quiet, whatever state_q holds.
    assign source_valid = src_valid_c & ~reset;
    assign source_sop   = src_sop_c & source_valid;
    assign source_eop   = src_eop_c & source_valid;
    assign sink0_ready  = sink0_ready_c & ~reset;
    assign sink1_ready  = sink1_ready_c & ~reset;

    assign stat_grant    = reset ? 2'b00
                                 : {(state_q == ST_GRANT1) || (state_q == ST_FLUSH1),
                                    (state_q == ST_GRANT0) || (state_q == ST_FLUSH0)};
    assign stat_pkt_cnt0 = pkt_cnt0_q;
    assign stat_pkt_cnt1 = pkt_cnt1_q;
    assign stat_err      = err_q;

endmodule

// File: tb/tb_rgb666_pkt_arbiter.sv
// tb_rgb666_pkt_arbiter
// Directed bench for rgb666_pkt_arbiter. Two per-channel source queues feed
// the sinks. Expected output beats, together with the cycle in which each
// must appear, are queued when the stimulus is built and popped as the
// converter side accepts beats. The watchdog limit is set to 4 beats.
module tb_rgb666_pkt_arbiter;

    localparam int DATA_W    = 96;
    localparam int EMPTY_W   = 4;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } sbeat_t;

    typedef struct {
        logic [1:0]         grant;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
        int                 cyc;
    } ebeat_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         cfg_enable;
    logic               sink0_valid, sink0_sop, sink0_eop, sink0_ready;
    logic [EMPTY_W-1:0] sink0_empty;
    logic [DATA_W-1:0]  sink0_data;
    logic               sink1_valid, sink1_sop, sink1_eop, sink1_ready;
    logic [EMPTY_W-1:0] sink1_empty;
    logic [DATA_W-1:0]  sink1_data;
    logic               source_ready;
    logic               source_valid, source_sop, source_eop;
    logic [EMPTY_W-1:0] source_empty;
    logic [DATA_W-1:0]  source_data;
    logic [1:0]         stat_grant;
    logic [CNT_W-1:0]   stat_pkt_cnt0, stat_pkt_cnt1;
    logic               stat_err;

    sbeat_t srcq0[$];
    sbeat_t srcq1[$];
    ebeat_t exp_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic src_rdy = 1'b1;
    logic smp_valid, smp_sink0_ready, smp_sink1_ready;
    logic [1:0] smp_grant;

    rgb666_pkt_arbiter #(
        .DATA_W   (DATA_W),
        .EMPTY_W  (EMPTY_W),
        .MAX_BEATS(MAX_BEATS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_enable   (cfg_enable),
        .sink0_valid  (sink0_valid),
        .sink0_sop    (sink0_sop),
        .sink0_eop    (sink0_eop),
        .sink0_empty  (sink0_empty),
        .sink0_data   (sink0_data),
        .sink0_ready  (sink0_ready),
        .sink1_valid  (sink1_valid),
        .sink1_sop    (sink1_sop),
        .sink1_eop    (sink1_eop),
        .sink1_empty  (sink1_empty),
        .sink1_data   (sink1_data),
        .sink1_ready  (sink1_ready),
        .source_ready (source_ready),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_empty (source_empty),
        .source_data  (source_data),
        .stat_grant   (stat_grant),
        .stat_pkt_cnt0(stat_pkt_cnt0),
        .stat_pkt_cnt1(stat_pkt_cnt1),
        .stat_err     (stat_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_src(input int ch, input logic sop, input logic eop,
                            input logic [EMPTY_W-1:0] empty, input logic [DATA_W-1:0] data);
        sbeat_t b;
        b = '{sop: sop, eop: eop, empty: empty, data: data};
        if (ch == 0) srcq0.push_back(b);
        else         srcq1.push_back(b);
    endtask

    task automatic push_exp(input int ch, input logic sop, input logic eop,
                            input logic [EMPTY_W-1:0] empty, input logic [DATA_W-1:0] data,
                            input int c);
        ebeat_t e;
        e.grant = (ch == 0) ? 2'b01 : 2'b10;
        e.sop   = sop;
        e.eop   = eop;
        e.empty = empty;
        e.data  = data;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    // Whole packet with random payload. Beat i must leave at first_cyc + i*stride.
    task automatic push_pkt(input int ch, input int n, input int first_cyc, input int stride);
        logic [DATA_W-1:0]  d;
        logic [EMPTY_W-1:0] em;
        for (int i = 0; i < n; i++) begin
            d  = {$urandom(), $urandom(), $urandom()};
            em = (i == n - 1) ? EMPTY_W'($urandom_range(0, 3)) : '0;
            push_src(ch, i == 0, i == n - 1, em, d);
            push_exp(ch, i == 0, i == n - 1, em, d, first_cyc + i * stride);
        end
    endtask

    // One clock: drive queue heads, sample at negedge, score any transfer,
    // retire accepted source beats at the edge. Starts and ends at posedge+1.
    task automatic tick();
        logic   acc0, acc1;
        ebeat_t e;
        sink0_valid = (srcq0.size() != 0);
        sink1_valid = (srcq1.size() != 0);
        if (sink0_valid) {sink0_sop, sink0_eop, sink0_empty, sink0_data} = srcq0[0];
        else             {sink0_sop, sink0_eop, sink0_empty, sink0_data} = '0;
        if (sink1_valid) {sink1_sop, sink1_eop, sink1_empty, sink1_data} = srcq1[0];
        else             {sink1_sop, sink1_eop, sink1_empty, sink1_data} = '0;
        source_ready = src_rdy;
        @(negedge clk);
        smp_valid       = source_valid;
        smp_sink0_ready = sink0_ready;
        smp_sink1_ready = sink1_ready;
        smp_grant       = stat_grant;
        acc0 = sink0_valid & sink0_ready;
        acc1 = sink1_valid & sink1_ready;
        if (source_valid && source_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(cyc), 128'(-1));
            end else begin
                e = exp_q.pop_front();
                check("beat", 128'({stat_grant, source_sop, source_eop, source_empty, source_data}),
                              128'({e.grant, e.sop, e.eop, e.empty, e.data}));
                if (e.cyc >= 0) check("beat_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        @(posedge clk);
        if (acc0) srcq0.delete(0);
        if (acc1) srcq1.delete(0);
        cyc++;
        #1;
    endtask

    // Run until all stimulus is consumed and all expected beats seen, bounded.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || srcq0.size() != 0 || srcq1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 128'(exp_q.size() + srcq0.size() + srcq1.size()), 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        srcq0.delete();
        srcq1.delete();
        exp_q.delete();
        src_rdy    = 1'b1;
        cfg_enable = 2'b11;
        repeat (2) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_enable = 2'b11;
        {sink0_valid, sink0_sop, sink0_eop, sink0_empty, sink0_data} = '0;
        {sink1_valid, sink1_sop, sink1_eop, sink1_empty, sink1_data} = '0;
        source_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_idle", 128'({source_valid, source_sop, source_eop, stat_grant, stat_err}), 128'(0));
        check("rst_cnt", 128'({stat_pkt_cnt0, stat_pkt_cnt1}), 128'(0));

        // Both channels request together: ch0 first, one bubble, then ch1
        push_pkt(0, 3, 1, 1);
        push_pkt(1, 3, 5, 1);
        drain(20);
        check("tie_cnt0", 128'(stat_pkt_cnt0), 128'(1));
        check("tie_cnt1", 128'(stat_pkt_cnt1), 128'(1));
        check("tie_err", 128'(stat_err), 128'(0));

        // Round robin: ch0 streams, ch1 asks once -> ch0, ch1, ch0, ch0
        do_reset();
        push_pkt(0, 2, 1, 1);
        push_pkt(1, 2, 4, 1);
        push_pkt(0, 2, 7, 1);
        push_pkt(0, 2, 10, 1);
        drain(30);
        check("rr_cnt0", 128'(stat_pkt_cnt0), 128'(3));
        check("rr_cnt1", 128'(stat_pkt_cnt1), 128'(1));

        // Backpressure on a 4-beat ch1 packet (eop exactly on the watchdog limit)
        do_reset();
        push_pkt(1, 4, 1, 2);
        for (int i = 0; i < 8; i++) begin
            src_rdy = (i == 0) || (i % 2 == 1);
            tick();
            if (i > 0) begin
                check("bp_ready1", 128'(smp_sink1_ready), 128'(i % 2 == 1));
                check("bp_ready0", 128'(smp_sink0_ready), 128'(0));
            end
        end
        src_rdy = 1'b1;
        drain(5);
        check("bp_cnt1", 128'(stat_pkt_cnt1), 128'(1));
        check("bp_err", 128'(stat_err), 128'(0));

        // Watchdog: 6-beat ch0 packet, cut at beat 4, beats 5-6 flushed
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [DATA_W-1:0] d;
            d = {$urandom(), $urandom(), $urandom()};
            push_src(0, i == 0, i == 5, '0, d);
            if (i < 4) push_exp(0, i == 0, i == 3, '0, d, i + 1);
        end
        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wd_flush_valid", 128'(smp_valid), 128'(0));
            check("wd_flush_ready", 128'(smp_sink0_ready), 128'(1));
        end
        tick();
        check("wd_idle_grant", 128'(smp_grant), 128'(0));
        check("wd_drained", 128'(exp_q.size() + srcq0.size()), 128'(0));
        check("wd_cnt0", 128'(stat_pkt_cnt0), 128'(1));
        check("wd_err", 128'(stat_err), 128'(1));

        // Disabled channel is ignored; enabled stray beat is dropped and flagged
        do_reset();
        cfg_enable = 2'b10;
        push_src(0, 1'b1, 1'b0, '0, {3{32'hA5A5_0001}});
        push_src(0, 1'b0, 1'b1, '0, {3{32'hA5A5_0002}});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dis_ready0", 128'({smp_sink0_ready, smp_valid, smp_grant}), 128'(0));
        end
        check("dis_err", 128'(stat_err), 128'(0));
        srcq0.delete();
        cfg_enable = 2'b11;
        push_src(0, 1'b0, 1'b1, '0, {3{32'h5A5A_0003}});
        tick();
        check("stray_ready0", 128'({smp_sink0_ready, smp_valid}), 128'(2'b10));
        check("stray_err", 128'(stat_err), 128'(1));
        check("stray_consumed", 128'(srcq0.size()), 128'(0));

        // Reset on beat 2 of a ch1 packet abandons it; ch0 is then served normally
        do_reset();
        push_pkt(1, 2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] d;
            d = {$urandom(), $urandom(), $urandom()};
            push_src(1, i == 0, i == 3, '0, d);
            if (i == 0) push_exp(1, 1'b1, 1'b0, '0, d, 4);
        end
        repeat (5) tick();
        check("mid_cnt1", 128'(stat_pkt_cnt1), 128'(1));
        reset = 1'b1;
        tick();
        check("mid_rst_hs", 128'({smp_valid, smp_sink1_ready, smp_grant}), 128'(0));
        reset = 1'b0;
        srcq1.delete();
        check("mid_after", 128'({source_valid, stat_grant, stat_pkt_cnt0, stat_pkt_cnt1, stat_err}), 128'(0));
        check("mid_exp_left", 128'(exp_q.size()), 128'(0));
        push_pkt(0, 2, 7, 1);
        drain(10);
        check("mid_cnt0", 128'(stat_pkt_cnt0), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb666_pkt_arbiter.md
# rgb666_pkt_arbiter

Two-input Avalon-ST packet arbiter that shares the single RGB666-to-RGBA8888 widening converter between two video sources: 4 pixels × 24 bit per beat, 96-bit data. Grants whole packets (sop..eop) with round-robin fairness and per-channel enable. A beat watchdog force-terminates runaway packets, and the block keeps per-channel packet counters and a sticky error flag. It sits directly upstream of the converter sink port.

## Interface
- DATA_W, 96, beat data width (4 × RGB666)
- EMPTY_W, 4, empty field width
- MAX_BEATS, 2048, watchdog limit on accepted beats per packet (≥2)
- CNT_W, 16, packet counter width
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- cfg_enable  in  2  bit N enables channel N arbitration
- sinkN_valid / sinkN_sop / sinkN_eop  in  1 each  channel N (N=0,1) framing
- sinkN_empty  in  EMPTY_W  channel N empty
- sinkN_data  in  DATA_W  channel N pixels
- sinkN_ready  out  1  channel N backpressure
- source_ready  in  1  from converter
- source_valid / source_sop / source_eop  out  1 each  to converter
- source_empty  out  EMPTY_W;  source_data  out  DATA_W
- stat_grant  out  2  one-hot current owner, 0 when idle
- stat_pkt_cnt0 / stat_pkt_cnt1  out  CNT_W  completed packets per channel
- stat_err  out  1  sticky error, cleared only by reset

## Operation
- States: IDLE, GRANT0, GRANT1, FLUSH0, FLUSH1. Register last_owner.
- IDLE:
  - reqN = sinkN_valid & sinkN_sop & cfg_enable[N].
  - Both requesting: grant the channel != last_owner; otherwise grant the sole requester. Move to GRANTN next cycle.
  - No beat is forwarded in IDLE. source_valid=0.
  - Stray beats (sinkN_valid & !sinkN_sop & cfg_enable[N]) are discarded: sinkN_ready=1 for that channel, and stat_err is set.
  - Disabled channel: sinkN_ready=0.
- GRANTN:
  - source_* = sinkN_* (combinational mux). sinkN_ready=source_ready. The other channel's ready=0.
  - beat = sinkN_valid & source_ready. beat_cnt increments per beat and clears on entry.
  - beat with eop: stat_pkt_cntN++ (wraps modulo 2^CNT_W), last_owner=N, go to IDLE.
  - beat with sop and beat_cnt>0: forwarded with source_sop forced 0, stat_err set.
  - cfg_enable[N] deasserted mid-packet: the packet still completes.
  - Beat number MAX_BEATS without eop: forwarded with source_eop forced 1, stat_pkt_cntN++, stat_err set, go to FLUSHN.
- FLUSHN: sinkN_ready=1, source_valid=0, beats dropped. The accepted beat with eop sets last_owner=N and returns to IDLE.
- Single-beat packet (sop & eop): legal. GRANTN → IDLE after one beat.
- Reset values:
  - state=IDLE, last_owner=1 (so channel 0 wins the first tie).
  - beat_cnt=0, counters=0, stat_err=0, stat_grant=0.
  - source_valid=0, sink0_ready=sink1_ready=0 while reset is high.
  - Reset mid-packet abandons the packet immediately; no eop is emitted.

## Timing
- Arbitration latency: request seen in IDLE → first beat can transfer the following cycle.
- One idle bubble between consecutive packets, always, including the same channel back-to-back.
- Within a packet: full throughput, zero added latency. Data, sop, eop, empty and valid pass combinationally.
- Ready uses readyLatency 0. sinkN_ready depends only on state, cfg_enable, source_ready and (IDLE only) sinkN_valid/sop. It never depends on source_valid.
- Outputs with source_valid=0: data/empty don't-care; sop/eop driven 0.
- stat_* update on the clock edge after the qualifying beat.

## Test plan
- Reset, then both channels present a 3-beat packet with cfg_enable=2'b11 → ch0 packet first, 1 bubble, then ch1. stat_pkt_cnt0=1, stat_pkt_cnt1=1, stat_err=0. Output data is bit-identical to input.
- Ch0 streams packets continuously, ch1 requests once → order ch0, ch1, ch0 (alternation). Ch1 is never starved beyond one packet.
- source_ready toggles 1,0,1,0 during a 4-beat ch1 packet → sink1_ready mirrors it, and exactly 4 beats transfer with sop on beat 1 and eop on beat 4.
- MAX_BEATS=4, ch0 sends 6 beats, eop on beat 6 → beat 4 has source_eop=1. Beats 5–6 are dropped (source_valid=0). stat_err=1, stat_pkt_cnt0=1, state returns to IDLE.
- cfg_enable=2'b10, ch0 valid with sop → sink0_ready=0, no grant. Ch0 beat without sop while enabled → dropped, stat_err=1.
- Reset asserted on beat 2 of a ch1 packet → next cycle source_valid=0, stat_grant=0, counters=0. A new sop packet on ch0 is granted with normal latency.
